iq_correlator: RTL and testbench

Receive-side counterpart of the 16-phase local-oscillator cosine generator. It multiplies an incoming signed 9-bit sample stream by an internal 16-entry cosine/sine table, amplitude 100, locked to the same phase sequence. Over a programmable window of whole LO periods it integrates the I and Q products and presents the two sums with a one-cycle valid strobe. It sits downstream of the mixer/ADC path and feeds phase/amplitude detection logic.

---
 rtl/iq_correlator.sv | 233 +++++++++++++++++++++++
 tb/tb_iq_correlator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_correlator.sv
// iq_correlator: I/Q correlator against a 16-phase LO table over PERIODS periods.
// Optional IQ_CORR_MAG_EN adds a registered L1 magnitude on mag_out.
module iq_correlator #(
  parameter int PERIODS = 4,
  parameter int ACC_W   = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [8:0]              sample_in,
  input  logic                    sample_valid,
  output logic                    busy,
  output logic signed [ACC_W-1:0] i_out,
  output logic signed [ACC_W-1:0] q_out,
  output logic [ACC_W:0]          mag_out,
  output logic                    result_valid
);

  localparam int NS = 16 * PERIODS;
  localparam int CW = 9;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FLUSH
  } state_t;

  state_t state;
  state_t state_n;

  logic [1:0]    fcnt;
  logic [1:0]    fcnt_n;
  logic [3:0]    p;
  logic [CW-1:0] cnt;

  logic clr;
  logic take;
  logic load;
  logic last;

  logic signed [7:0]  cos_v;
  logic signed [7:0]  sin_v;
  logic signed [17:0] smp_x;
  logic signed [17:0] cos_x;
  logic signed [17:0] sin_x;
  logic signed [17:0] mul_i;
  logic signed [17:0] mul_q;
  logic signed [17:0] prod_i;
  logic signed [17:0] prod_q;
  logic               prod_vld;

  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;

  function automatic logic signed [7:0] cos_lut(
    input logic [3:0] idx
  );
    logic signed [7:0] v;
    v = '0;
    case (idx)
      4'd0:  v = 8'sd100;
      4'd1:  v = 8'sd92;
      4'd2:  v = 8'sd71;
      4'd3:  v = 8'sd38;
      4'd4:  v = 8'sd0;
      4'd5:  v = -8'sd38;
      4'd6:  v = -8'sd71;
      4'd7:  v = -8'sd92;
      4'd8:  v = -8'sd100;
      4'd9:  v = -8'sd92;
      4'd10: v = -8'sd71;
      4'd11: v = -8'sd38;
      4'd12: v = 8'sd0;
      4'd13: v = 8'sd38;
      4'd14: v = 8'sd71;
      4'd15: v = 8'sd92;
      default: v = 8'sd0;
    endcase
    return v;
  endfunction

  // sine is the cosine table delayed by a quarter period
  assign cos_v = cos_lut(p);
  assign sin_v = cos_lut(p + 4'd12);

  assign smp_x = {{9{sample_in[8]}}, sample_in};
  assign cos_x = {{10{cos_v[7]}}, cos_v};
  assign sin_x = {{10{sin_v[7]}}, sin_v};
  assign mul_i = smp_x * cos_x;
  assign mul_q = smp_x * sin_x;

  assign last = (cnt == CW'(NS - 1));
  assign busy = (state != IDLE);

  // FSM state and flush-step register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
    end
  end

  // next state and per-cycle control strobes
  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    clr     = 1'b0;
    take    = 1'b0;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_n = ACCUM;
        end
      end
      ACCUM: begin
        if (sample_valid) begin
          take = 1'b1;
          if (last) begin
            state_n = FLUSH;
            fcnt_n  = '0;
          end
        end
      end
      FLUSH: begin
        fcnt_n = fcnt + 2'd1;
        unique case (1'b1)
          (fcnt == 2'd0): ;
          (fcnt == 2'd1): load = 1'b1;
          (fcnt == 2'd2): begin
            state_n = IDLE;
            fcnt_n  = '0;
          end
          default: begin
            state_n = IDLE;
            fcnt_n  = '0;
          end
        endcase
      end
      default: begin
        state_n = IDLE;
        fcnt_n  = '0;
      end
    endcase
  end

  // LO phase and accepted-sample count advance only on taken samples
  always_ff @(posedge clk) begin
    if (rst) begin
      p   <= '0;
      cnt <= '0;
    end else if (clr) begin
      p   <= '0;
      cnt <= '0;
    end else if (take) begin
      p   <= p + 4'd1;
      cnt <= cnt + CW'(1);
    end
  end

  // stage 1: register the two products of the accepted sample
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_vld <= 1'b0;
      prod_i   <= '0;
      prod_q   <= '0;
    end else begin
      prod_vld <= take;
      if (take) begin
        prod_i <= mul_i;
        prod_q <= mul_q;
      end
    end
  end

  // stage 2: wrapping accumulation of the registered products
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_i <= '0;
      acc_q <= '0;
    end else if (clr) begin
      acc_i <= '0;
      acc_q <= '0;
    end else if (prod_vld) begin
      acc_i <= acc_i + ACC_W'(prod_i);
      acc_q <= acc_q + ACC_W'(prod_q);
    end
  end

  // result registers and the one-cycle strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      i_out        <= '0;
      q_out        <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= load;
      if (load) begin
        i_out <= acc_i;
        q_out <= acc_q;
      end
    end
  end

`ifdef IQ_CORR_MAG_EN
  logic signed [ACC_W:0] ext_i;
  logic signed [ACC_W:0] ext_q;
  logic [ACC_W:0]        abs_i;
  logic [ACC_W:0]        abs_q;

  // widen before negating so the most negative value has a magnitude
  assign ext_i = {acc_i[ACC_W-1], acc_i};
  assign ext_q = {acc_q[ACC_W-1], acc_q};
  assign abs_i = ext_i[ACC_W] ? $unsigned(-ext_i) : $unsigned(ext_i);
  assign abs_q = ext_q[ACC_W] ? $unsigned(-ext_q) : $unsigned(ext_q);

  // L1 magnitude registered alongside i_out/q_out
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_out <= '0;
    end else if (load) begin
      mag_out <= abs_i + abs_q;
    end
  end
`else
  assign mag_out = '0;
`endif

endmodule

// File: tb/tb_iq_correlator.sv
// tb_iq_correlator: table vectors, corner sequences and random windows
// for iq_correlator at PERIODS=1 and PERIODS=4.
module tb_iq_correlator;

  localparam int AW = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sel4;
  logic [8:0]  sample_in;
  logic        sample_valid;

  logic s1;
  logic s4;
  logic b1;
  logic b4;
  logic r1;
  logic r4;
  logic signed [AW-1:0] i1;
  logic signed [AW-1:0] q1;
  logic signed [AW-1:0] i4;
  logic signed [AW-1:0] q4;
  logic [AW:0] m1;
  logic [AW:0] m4;

  logic busy_s;
  logic rv_s;
  logic signed [AW-1:0] i_s;
  logic signed [AW-1:0] q_s;
  logic [AW:0] m_s;

  assign s1 = start & ~sel4;
  assign s4 = start & sel4;
  assign busy_s = sel4 ? b4 : b1;
  assign rv_s   = sel4 ? r4 : r1;
  assign i_s    = sel4 ? i4 : i1;
  assign q_s    = sel4 ? q4 : q1;
  assign m_s    = sel4 ? m4 : m1;

  iq_correlator #(.PERIODS(1), .ACC_W(AW)) u1 (
    .clk(clk), .rst(rst), .start(s1),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .busy(b1), .i_out(i1), .q_out(q1),
    .mag_out(m1), .result_valid(r1)
  );

  iq_correlator #(.PERIODS(4), .ACC_W(AW)) u4 (
    .clk(clk), .rst(rst), .start(s4),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .busy(b4), .i_out(i4), .q_out(q4),
    .mag_out(m4), .result_valid(r4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int cosv[16] = '{100, 92, 71, 38, 0, -38, -71, -92,
                   -100, -92, -71, -38, 0, 38, 71, 92};

  int stim[$];
  longint got_i;
  longint got_q;
  longint got_m;

  typedef struct {
    string nm;
    bit    p4;
    int    kind;
    int    gap;
    int    ei;
    int    eq;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic longint wrap(input longint v);
    logic signed [AW-1:0] t;
    t = v[AW-1:0];
    return longint'(t);
  endfunction

  function automatic longint mag_exp(input longint a, input longint b);
`ifdef IQ_CORR_MAG_EN
    return (a < 0 ? -a : a) + (b < 0 ? -b : b);
`else
    return 0;
`endif
  endfunction

  function automatic int gen(input int kind, input int k);
    case (kind)
      0: return cosv[k % 16];
      1: return cosv[(k + 12) % 16];
      2: return 50;
      3: return -cosv[k % 16];
      4: return -256;
      5: return 2 * cosv[k % 16];
      default: return 0;
    endcase
  endfunction

  // dot products of the accepted samples with the LO tables
  task automatic model(output longint ei, output longint eq);
    longint si;
    longint sq;
    si = 0;
    sq = 0;
    foreach (stim[k]) begin
      si += longint'(stim[k]) * cosv[k % 16];
      sq += longint'(stim[k]) * cosv[(k + 12) % 16];
    end
    ei = wrap(si);
    eq = wrap(sq);
  endtask

  // gap: 0 none, 1 one idle cycle between samples, 2 random idles
  task automatic run(input string nm, input bit p4, input int gap,
                     input bit restart);
    int n;
    int waitc;
    int g;
    n = p4 ? 64 : 16;
    sel4 = p4;
    start = 1'b1;
    sample_valid = 1'b1;
    sample_in = 9'h0ff;
    tick();
    start = 1'b0;
    chk({nm, " busy_on_start"}, longint'(busy_s), 1);
    for (int k = 0; k < n; k++) begin
      g = (gap == 1) ? ((k > 0) ? 1 : 0)
        : (gap == 2) ? int'($urandom_range(0, 3)) : 0;
      repeat (g) begin
        sample_valid = 1'b0;
        sample_in = 9'($urandom);
        tick();
      end
      sample_valid = 1'b1;
      sample_in = 9'(stim[k]);
      start = restart && (k == 5);
      tick();
      start = 1'b0;
    end
    sample_valid = 1'b1;
    start = restart;
    waitc = 0;
    while (!rv_s && waitc < 10) begin
      sample_in = 9'($urandom);
      tick();
      waitc++;
    end
    chk({nm, " strobe_latency"}, waitc, 2);
    got_i = longint'(i_s);
    got_q = longint'(q_s);
    got_m = longint'(m_s);
    start = 1'b0;
    sample_valid = 1'b0;
    tick();
    chk({nm, " strobe_one_cycle"}, longint'(rv_s), 0);
    chk({nm, " busy_off"}, longint'(busy_s), 0);
  endtask

  initial begin
    longint ei;
    longint eq;
    int rvc;

    vecs[0] = '{"cos1",    1'b0, 0, 0, 79796, 0};
    vecs[1] = '{"sin1",    1'b0, 1, 0, 0, 79796};
    vecs[2] = '{"dc50",    1'b0, 2, 0, 0, 0};
    vecs[3] = '{"ncos1",   1'b0, 3, 0, -79796, 0};
    vecs[4] = '{"dcmin",   1'b0, 4, 2, 0, 0};
    vecs[5] = '{"cos4tog", 1'b1, 0, 1, 319184, 0};
    vecs[6] = '{"sin4",    1'b1, 1, 0, 0, 319184};
    vecs[7] = '{"cos2x",   1'b0, 5, 2, 159592, 0};

    rst = 1'b1;
    start = 1'b0;
    sel4 = 1'b0;
    sample_in = '0;
    sample_valid = 1'b0;
    repeat (3) tick();
    chk("rst busy1", longint'(b1), 0);
    chk("rst busy4", longint'(b4), 0);
    chk("rst rv1", longint'(r1), 0);
    chk("rst i1", longint'(i1), 0);
    chk("rst q4", longint'(q4), 0);
    chk("rst mag1", longint'(m1), 0);
    rst = 1'b0;
    tick();

    foreach (vecs[v]) begin
      int n;
      n = vecs[v].p4 ? 64 : 16;
      stim.delete();
      for (int k = 0; k < n; k++) stim.push_back(gen(vecs[v].kind, k));
      run(vecs[v].nm, vecs[v].p4, vecs[v].gap, 1'b0);
      chk({vecs[v].nm, " i"}, got_i, vecs[v].ei);
      chk({vecs[v].nm, " q"}, got_q, vecs[v].eq);
      chk({vecs[v].nm, " mag"}, got_m,
          mag_exp(vecs[v].ei, vecs[v].eq));
    end

    // reset part-way through a window
    sel4 = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      sample_valid = 1'b1;
      sample_in = 9'(cosv[k]);
      tick();
    end
    rst = 1'b1;
    sample_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrst i", longint'(i_s), 0);
    chk("midrst q", longint'(q_s), 0);
    chk("midrst mag", longint'(m_s), 0);
    chk("midrst busy", longint'(busy_s), 0);
    rvc = 0;
    sample_valid = 1'b1;
    repeat (20) begin
      sample_in = 9'($urandom);
      tick();
      if (rv_s) rvc++;
    end
    sample_valid = 1'b0;
    chk("midrst no_strobe", rvc, 0);
    stim.delete();
    for (int k = 0; k < 16; k++) stim.push_back(cosv[k]);
    run("after_rst", 1'b0, 0, 1'b0);
    chk("after_rst i", got_i, 79796);

    // start pulses while busy are ignored
    run("restart", 1'b0, 0, 1'b1);
    chk("restart i", got_i, 79796);
    chk("restart q", got_q, 0);

    // rst and start together
    rst = 1'b1;
    start = 1'b1;
    tick();
    chk("rst_start busy", longint'(busy_s), 0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    chk("rst_start idle", longint'(busy_s), 0);
    chk("rst_start rv", longint'(rv_s), 0);

    // random samples and gaps against the dot-product model
    for (int r = 0; r < 6; r++) begin
      int n;
      bit p4;
      p4 = (r % 2) == 1;
      n = p4 ? 64 : 16;
      stim.delete();
      for (int k = 0; k < n; k++)
        stim.push_back(int'($urandom_range(0, 511)) - 256);
      model(ei, eq);
      run($sformatf("rand%0d", r), p4, 2, 1'b0);
      chk($sformatf("rand%0d i", r), got_i, ei);
      chk($sformatf("rand%0d q", r), got_q, eq);
      chk($sformatf("rand%0d mag", r), got_m, mag_exp(ei, eq));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
